sram_arbiter: RTL

- Two-port arbiter and sequencer for the board's 256K x 32 asynchronous SRAM (two 16-bit chips, A = low half, B = high half, shared address/WE/OE).
- Grants one requester at a time using round-robin arbitration.
- Generates the SRAM control strobe sequence, drives and tri-states the shared data buses, and returns read data with a single-cycle acknowledge.
- Sits between the starter-kit top-level SRAM pins and user logic, for example a VGA frame fetcher on port 0 and a CPU/UART loader on port 1.

---
 rtl/sram_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and strobe sequencer for a 256K x 32 async SRAM
// built from two 16-bit chips (A = low half, B = high half) that share
// address, WE and OE.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   Pn_REQ/WE/ADDR/WDATA/BE  requester n (n = 0, 1); REQ is a level, and the
//                            other fields are held stable until ACK
//   Pn_ACK, Pn_RDATA         one-cycle completion pulse, last read data
//   SRAM_A, SRAM_WE_X, SRAM_OE_X, SRAM_IO_A/B, SRAM_CE/LB/UB_A/B_X  SRAM pins
//
// Sequence per access: IDLE -> SETUP (1) -> ACCESS (WAIT_CYCLES) -> DONE (1).
// Optional feature macro: SRAM_ARBITER_FIXED_PRIORITY_EN (port 0 always wins
// simultaneous requests). When it is undefined, arbitration is round-robin.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        P0_REQ,
  input  logic        P0_WE,
  input  logic [17:0] P0_ADDR,
  input  logic [31:0] P0_WDATA,
  input  logic [3:0]  P0_BE,
  output logic        P0_ACK,
  output logic [31:0] P0_RDATA,
  input  logic        P1_REQ,
  input  logic        P1_WE,
  input  logic [17:0] P1_ADDR,
  input  logic [31:0] P1_WDATA,
  input  logic [3:0]  P1_BE,
  output logic        P1_ACK,
  output logic [31:0] P1_RDATA,
  output logic [17:0] SRAM_A,
  output logic        SRAM_WE_X,
  output logic        SRAM_OE_X,
  inout  wire  [15:0] SRAM_IO_A,
  output logic        SRAM_CE_A_X,
  output logic        SRAM_LB_A_X,
  output logic        SRAM_UB_A_X,
  inout  wire  [15:0] SRAM_IO_B,
  output logic        SRAM_CE_B_X,
  output logic        SRAM_LB_B_X,
  output logic        SRAM_UB_B_X
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             gnt;       // port owning the current access
  logic             gnt_we;    // current access is a write
  logic             io_drive;
  logic [31:0]      io_wdata;

  logic             pick_c;
  logic             req_we_c;
  logic [17:0]      req_addr_c;
  logic [31:0]      req_wdata_c;
  logic [3:0]       req_be_c;

`ifndef SRAM_ARBITER_FIXED_PRIORITY_EN
  logic             last_gnt;
`endif

  // Arbitration and request mux of the port that would win this cycle
  always_comb begin
`ifdef SRAM_ARBITER_FIXED_PRIORITY_EN
    pick_c = ~P0_REQ;
`else
    if (P0_REQ && P1_REQ) pick_c = ~last_gnt;
    else                  pick_c = ~P0_REQ;
`endif
    req_we_c    = P0_WE;
    req_addr_c  = P0_ADDR;
    req_wdata_c = P0_WDATA;
    req_be_c    = P0_BE;
    if (pick_c) begin
      req_we_c    = P1_WE;
      req_addr_c  = P1_ADDR;
      req_wdata_c = P1_WDATA;
      req_be_c    = P1_BE;
    end
  end

  // Write data stays on the bus from SETUP through DONE for setup and hold
  assign SRAM_IO_A = io_drive ? io_wdata[15:0]  : 16'bz;
  assign SRAM_IO_B = io_drive ? io_wdata[31:16] : 16'bz;

  // Sequencer with registered SRAM controls and port responses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      gnt         <= 1'b0;
      gnt_we      <= 1'b0;
      io_drive    <= 1'b0;
      io_wdata    <= '0;
`ifndef SRAM_ARBITER_FIXED_PRIORITY_EN
      last_gnt    <= 1'b1;
`endif
      P0_ACK      <= 1'b0;
      P1_ACK      <= 1'b0;
      P0_RDATA    <= '0;
      P1_RDATA    <= '0;
      SRAM_A      <= '0;
      SRAM_WE_X   <= 1'b1;
      SRAM_OE_X   <= 1'b1;
      SRAM_CE_A_X <= 1'b1;
      SRAM_CE_B_X <= 1'b1;
      {SRAM_UB_B_X, SRAM_LB_B_X, SRAM_UB_A_X, SRAM_LB_A_X} <= 4'hF;
    end else begin
      P0_ACK <= 1'b0;
      P1_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (P0_REQ || P1_REQ) begin
            gnt         <= pick_c;
`ifndef SRAM_ARBITER_FIXED_PRIORITY_EN
            last_gnt    <= pick_c;
`endif
            gnt_we      <= req_we_c;
            SRAM_A      <= req_addr_c;
            SRAM_CE_A_X <= 1'b0;
            SRAM_CE_B_X <= 1'b0;
            wait_cnt    <= CNT_W'(WAIT_CYCLES - 1);
            if (req_we_c) begin
              SRAM_OE_X <= 1'b1;
              {SRAM_UB_B_X, SRAM_LB_B_X, SRAM_UB_A_X, SRAM_LB_A_X} <= ~req_be_c;
              io_drive  <= 1'b1;
              io_wdata  <= req_wdata_c;
            end else begin
              SRAM_OE_X <= 1'b0;
              {SRAM_UB_B_X, SRAM_LB_B_X, SRAM_UB_A_X, SRAM_LB_A_X} <= 4'h0;
              io_drive  <= 1'b0;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (gnt_we) SRAM_WE_X <= 1'b0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            SRAM_WE_X <= 1'b1;
            SRAM_OE_X <= 1'b1;
            if (!gnt_we) begin
              if (gnt) P1_RDATA <= {SRAM_IO_B, SRAM_IO_A};
              else     P0_RDATA <= {SRAM_IO_B, SRAM_IO_A};
            end
            if (gnt) P1_ACK <= 1'b1;
            else     P0_ACK <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Chip enables, lanes and the bus are released on the way back to IDLE
          SRAM_CE_A_X <= 1'b1;
          SRAM_CE_B_X <= 1'b1;
          {SRAM_UB_B_X, SRAM_LB_B_X, SRAM_UB_A_X, SRAM_LB_A_X} <= 4'hF;
          io_drive    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
